// File: rtl/arb_pkg.sv
// Helpers shared with the request/grant arbiter family: index/one-hot
// conversion and the credit counter width derivation.
package arb_pkg;

  localparam int MAX_W = 32;

  function automatic int cnt_width(input int credits);
    return $clog2(credits + 1);
  endfunction

  function automatic int unsigned onehot2idx(input logic [MAX_W-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

  function automatic logic [MAX_W-1:0] idx2onehot(input int unsigned idx);
    logic [MAX_W-1:0] oh;
    oh = '0;
    oh[idx[4:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot picker: lowest set bit above last_ptr, else lowest set bit overall.
module rr_pick #(
  parameter int WIDTH = 4,
  parameter int PTR_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [WIDTH-1:0] pick
);

  logic [WIDTH-1:0] mask, masked;

  for (genvar i = 0; i < WIDTH; i++) begin : g_mask
    assign mask[i] = (PTR_W'(i) > last_ptr);
  end

  assign masked = vec & mask;

  // x & -x isolates the lowest set bit
  always_comb begin
    pick = '0;
    if (|masked) pick = masked & (~masked + 1'b1);
    else         pick = vec & (~vec + 1'b1);
  end

endmodule

// File: rtl/rr_credit_dispatcher.sv
// Round-robin fan-out of one stream to DEST_NUM sinks, bounded by per-sink credits.
// Registered output, one dispatch per cycle.
module rr_credit_dispatcher
  import arb_pkg::*;
#(
  parameter int DEST_NUM   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DEST_NUM-1:0]   out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [DEST_NUM-1:0]   credit_ret,
  output logic [DEST_NUM-1:0]   credit_avail,
  output logic                  credit_err
);

  localparam int CNT_W = cnt_width(CREDITS);
  localparam int PTR_W = $clog2(DEST_NUM);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

  logic [DEST_NUM-1:0][CNT_W-1:0] cnt;
  logic [PTR_W-1:0]               last_ptr;
  logic [DEST_NUM-1:0]            eligible, sel, dec, ovf;
  logic                           fire;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < DEST_NUM; i++) eligible[i] = (cnt[i] != '0);
  end

  rr_pick #(.WIDTH(DEST_NUM), .PTR_W(PTR_W)) u_pick (
    .vec      (eligible),
    .last_ptr (last_ptr),
    .pick     (sel)
  );

  assign in_ready     = |eligible;
  assign credit_avail = eligible;
  assign fire         = in_valid & in_ready;
  assign dec          = fire ? sel : '0;

  // A return that lands on a full counter with no matching dispatch is lost
  always_comb begin
    ovf = '0;
    for (int i = 0; i < DEST_NUM; i++)
      ovf[i] = credit_ret[i] & ~dec[i] & (cnt[i] == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEST_NUM; i++) cnt[i] <= CNT_MAX;
    end else begin
      for (int i = 0; i < DEST_NUM; i++) begin
        if (credit_ret[i] && !dec[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !credit_ret[i])                 cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= '0;
      out_data   <= '0;
      last_ptr   <= PTR_W'(DEST_NUM - 1);
      credit_err <= 1'b0;
    end else begin
      out_valid  <= dec;
      credit_err <= credit_err | (|ovf);
      if (fire) begin
        out_data <= in_data;
        last_ptr <= PTR_W'(onehot2idx(MAX_W'(sel)));
      end
    end
  end

endmodule
